// File: rtl/booth_mult_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// mult_sched_pkg
// Shared types and defaults for the Booth multiplier scheduler.
//   state_e   : scheduler FSM states (IDLE, LOAD, RUN, DONE), 2-bit encoding
//   MS_W      : default operand width
//   MS_MUL_LAT: default core iterations after the load cycle
//   MS_CNT_W  : iteration counter width for the defaults
//   cnt_w()   : counter width for an arbitrary latency (never below 1 bit)
// ----------------------------------------------------------------------------
package mult_sched_pkg;

    localparam int MS_W       = 8;
    localparam int MS_MUL_LAT = 8;
    localparam int MS_CNT_W   = $clog2(MS_MUL_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // A latency of 1 would give $clog2 == 0; keep at least one counter bit.
    function automatic int cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/booth_mult_scheduler_if.sv
// ----------------------------------------------------------------------------
// booth_mult_scheduler_if
// Bundles the requester side and the multiplier-core side of the scheduler.
//   req/req_a/req_b        : per-requester request level and signed operands
//   gnt/rsp_valid          : one-hot grant and response pulses
//   rsp_product            : signed 2W-bit product returned with rsp_valid
//   busy                   : scheduler is not idle
//   mul_load/mul_a/mul_b   : load strobe and operands to the core
//   mul_product            : core accumulator output
// Modports: master = clients + core (environment), slave = scheduler.
// ----------------------------------------------------------------------------
interface booth_mult_scheduler_if
    import mult_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = MS_W
);
    logic [N_REQ-1:0]          req;
    logic [N_REQ-1:0][W-1:0]   req_a;
    logic [N_REQ-1:0][W-1:0]   req_b;
    logic [N_REQ-1:0]          gnt;
    logic [N_REQ-1:0]          rsp_valid;
    logic [2*W-1:0]            rsp_product;
    logic                      busy;
    logic                      mul_load;
    logic [W-1:0]              mul_a;
    logic [W-1:0]              mul_b;
    logic [2*W-1:0]            mul_product;

    modport master (
        output req, req_a, req_b, mul_product,
        input  gnt, rsp_valid, rsp_product, busy, mul_load, mul_a, mul_b
    );

    modport slave (
        input  req, req_a, req_b, mul_product,
        output gnt, rsp_valid, rsp_product, busy, mul_load, mul_a, mul_b
    );
endinterface

// File: rtl/booth_mult_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set request at or after i_ptr,
// wrapping modulo N. The pointer register lives in the caller.
//   i_req   : request vector
//   i_ptr   : starting index for the search
//   i_en    : arbitration enable; no grant when low
//   o_gnt   : one-hot grant
//   o_idx   : index of the granted requester
//   o_valid : a grant was issued
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        logic w_found;
        int   j;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (i_en && !w_found && i_req[j]) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/booth_mult_scheduler.sv
// ----------------------------------------------------------------------------
// booth_mult_scheduler
// Shares one sequential Booth multiplier core among N_REQ requesters.
// Round-robin arbitration in IDLE, one LOAD cycle, MUL_LAT RUN cycles, then a
// one-cycle DONE that hands the core's product back to the owner.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (aborts any operation in flight)
//   io_bus : requester + core signals (slave modport)
// ----------------------------------------------------------------------------
module booth_mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = MS_W,
    parameter int MUL_LAT = MS_MUL_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    booth_mult_scheduler_if.slave  io_bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cnt_w(MUL_LAT);

    state_e          r_state;
    state_e          w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [CW-1:0]   r_cnt;

    logic [N_REQ-1:0] w_arb_gnt;
    logic [IW-1:0]    w_arb_idx;
    logic             w_arb_vld;
    logic [IW-1:0]    w_ptr_nxt;

    // Arbitration only runs while idle, so gnt can never fire mid-operation.
    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .i_req   (io_bus.req),
        .i_ptr   (r_ptr),
        .i_en    (r_state == IDLE),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_vld)
    );

    assign w_ptr_nxt = (int'(w_arb_idx) == N_REQ - 1) ? '0 : w_arb_idx + IW'(1);

    // State register plus operand/owner/counter bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_arb_vld) begin
                        r_a     <= io_bus.req_a[w_arb_idx];
                        r_b     <= io_bus.req_b[w_arb_idx];
                        r_owner <= w_arb_idx;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                LOAD: r_cnt <= CW'(MUL_LAT - 1);
                RUN:  if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Next state and outputs.
    always_comb begin
        w_next             = r_state;
        io_bus.gnt         = '0;
        io_bus.rsp_valid   = '0;
        io_bus.rsp_product = '0;
        io_bus.busy        = 1'b0;
        io_bus.mul_load    = 1'b0;
        io_bus.mul_a       = '0;
        io_bus.mul_b       = '0;

        case (r_state)
            IDLE: begin
                io_bus.gnt = w_arb_gnt;
                if (w_arb_vld) w_next = LOAD;
            end
            LOAD: begin
                io_bus.busy     = 1'b1;
                io_bus.mul_load = 1'b1;
                io_bus.mul_a    = r_a;
                io_bus.mul_b    = r_b;
                w_next          = RUN;
            end
            RUN: begin
                io_bus.busy  = 1'b1;
                io_bus.mul_a = r_a;
                io_bus.mul_b = r_b;
                if (r_cnt == '0) w_next = DONE;
            end
            DONE: begin
                io_bus.busy               = 1'b1;
                io_bus.mul_a              = r_a;
                io_bus.mul_b              = r_b;
                io_bus.rsp_valid[r_owner] = 1'b1;
                io_bus.rsp_product        = io_bus.mul_product;
                w_next                    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_booth_mult_scheduler.sv
module tb_booth_mult_scheduler;
  import mult_sched_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mult_scheduler_if #(.N_REQ(N), .W(W)) bus ();

  booth_mult_scheduler #(.N_REQ(N), .W(W), .MUL_LAT(LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Behavioural core: garbage while iterating, true product after LAT
  // iterations following the load; reads operands at the last iteration.
  int          c_cnt;
  logic [15:0] c_prod;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt  <= 0;
      c_prod <= '0;
    end else if (bus.mul_load) begin
      c_cnt  <= LAT;
      c_prod <= 16'hA5A5;
    end else if (c_cnt > 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) c_prod <= smul(bus.mul_a, bus.mul_b);
    end
  end
  assign bus.mul_product = c_prod;

  // Transaction-timeline reference: a grant at cycle g implies LOAD at g+1,
  // busy g+1..g+LAT+2, response at g+LAT+2, next grant possible at g+LAT+3.
  int          cyc   = 0;
  int          m_ptr = 0;
  int          m_g   = -1;
  int          m_own = 0;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_p;

  logic [N-1:0] seen_gnt;
  int           g_idx[$];
  int           g_cyc[$];
  logic [15:0]  last_prod;
  int           last_own;
  int           last_rsp_cyc;
  int           n_rsp = 0;
  bit           auto_drop = 1'b1;

  task automatic check_cycle();
    logic [N-1:0] eg, er;
    logic [15:0]  ep;
    logic         eb, el;
    int           d, pick;
    bit           idle;
    eg = '0; er = '0; ep = '0; eb = 1'b0; el = 1'b0;
    if (!rst_n) begin
      m_g   = -1;
      m_ptr = 0;
    end else begin
      d    = cyc - m_g;
      idle = (m_g < 0) || (d > LAT + 2);
      if (!idle) begin
        eb = 1'b1;
        el = (d == 1);
        if (d == LAT + 2) begin
          er[m_own] = 1'b1;
          ep        = m_p;
        end
      end else if (bus.req != '0) begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && bus.req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        m_own     = pick;
        eg[pick]  = 1'b1;
        m_g       = cyc;
        m_a       = bus.req_a[pick];
        m_b       = bus.req_b[pick];
        m_p       = smul(m_a, m_b);
        m_ptr     = (pick + 1) % N;
      end
    end
    chk("gnt",         32'(bus.gnt),         32'(eg));
    chk("rsp_valid",   32'(bus.rsp_valid),   32'(er));
    chk("rsp_product", 32'(bus.rsp_product), 32'(ep));
    chk("busy",        32'(bus.busy),        32'(eb));
    chk("mul_load",    32'(bus.mul_load),    32'(el));
    if (eb) begin
      chk("mul_a", 32'(bus.mul_a), 32'(m_a));
      chk("mul_b", 32'(bus.mul_b), 32'(m_b));
    end
    seen_gnt = bus.gnt;
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) begin
        g_idx.push_back(i);
        g_cyc.push_back(cyc);
      end
      if (bus.rsp_valid[i]) begin
        last_prod    = bus.rsp_product;
        last_own     = i;
        last_rsp_cyc = cyc;
        n_rsp++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_drop) bus.req = bus.req & ~seen_gnt;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(4))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, saved_rsp, saved_g;
    int exp_rr[5];
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    seen_gnt  = '0;

    // Reset state
    steps(3);
    rst_n = 1'b1;
    steps(2);

    // Single request, 3*5
    bus.req_a[0] = 8'd3;
    bus.req_b[0] = 8'd5;
    bus.req[0]   = 1'b1;
    steps(12);
    chk("t1_prod", 32'(last_prod), 32'h000F);
    chk("t1_own",  32'(last_own),  32'd0);
    chk("t1_lat",  32'(last_rsp_cyc - g_cyc[$]), 32'd10);

    // Signed operands
    bus.req_a[2] = 8'hFD;
    bus.req_b[2] = 8'h07;
    bus.req[2]   = 1'b1;
    steps(12);
    chk("t2_neg_prod", 32'(last_prod), 32'hFFEB);
    chk("t2_neg_own",  32'(last_own),  32'd2);
    bus.req_a[2] = 8'h80;
    bus.req_b[2] = 8'h80;
    bus.req[2]   = 1'b1;
    steps(12);
    chk("t2_min_prod", 32'(last_prod), 32'h4000);

    // Request while busy, pointer wraps 3->0
    bus.req_a[3] = 8'h11; bus.req_b[3] = 8'h22;
    bus.req_a[0] = 8'hC3; bus.req_b[0] = 8'h05;
    bus.req_a[1] = 8'h7F; bus.req_b[1] = 8'h80;
    bus.req[3]   = 1'b1;
    step();
    base = g_idx.size();
    steps(3);
    bus.req = bus.req | 4'b0011;
    steps(32);
    chk("t4_first_gnt", 32'(g_idx[base - 1]), 32'd3);
    chk("t4_wrap_idx",  32'(g_idx[base]),     32'd0);
    chk("t4_wrap_gap",  32'(g_cyc[base] - g_cyc[base - 1]), 32'd11);
    chk("t4_next_idx",  32'(g_idx[base + 1]), 32'd1);
    chk("t4_last_prod", 32'(last_prod), 32'(smul(8'h7F, 8'h80)));

    // Reset mid-run
    bus.req_a[2] = 8'h5A; bus.req_b[2] = 8'hA5;
    bus.req[2]   = 1'b1;
    step();
    steps(4);
    saved_rsp = n_rsp;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    chk("t5_rst_busy", 32'(bus.busy),        32'd0);
    chk("t5_rst_load", 32'(bus.mul_load),    32'd0);
    chk("t5_rst_rsp",  32'(bus.rsp_valid),   32'd0);
    chk("t5_rst_prod", 32'(bus.rsp_product), 32'd0);
    chk("t5_rst_mula", 32'(bus.mul_a),       32'd0);
    steps(2);
    rst_n = 1'b1;
    steps(15);
    chk("t5_no_rsp", 32'(n_rsp), 32'(saved_rsp));

    // Round-robin with all requests held (pointer restarts at 0)
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = rnd_op();
      bus.req_b[i] = rnd_op();
    end
    exp_rr = '{0, 1, 2, 3, 0};
    auto_drop = 1'b0;
    base    = g_idx.size();
    bus.req = 4'b1111;
    steps(55);
    bus.req   = '0;
    auto_drop = 1'b1;
    steps(12);
    for (int i = 0; i < 5; i++) begin
      chk("t3_rr_idx", 32'(g_idx[base + i]), 32'(exp_rr[i]));
      if (i > 0) chk("t3_rr_gap", 32'(g_cyc[base + i] - g_cyc[base + i - 1]), 32'd11);
    end

    // Idle stability
    saved_rsp = n_rsp;
    saved_g   = g_idx.size();
    steps(50);
    chk("t6_no_gnt", 32'(g_idx.size()), 32'(saved_g));
    chk("t6_no_rsp", 32'(n_rsp),        32'(saved_rsp));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(7) == 0) begin
          bus.req_a[i] = rnd_op();
          bus.req_b[i] = rnd_op();
          bus.req[i]   = 1'b1;
        end
      end
      step();
    end
    steps(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
